// File: rtl/ps2_position_sequencer.sv
// PS/2 set-2 keyboard receiver with a move/colour sequencer for the VGA sprite.
// Key actions accumulate in pending registers and are committed on the vsync falling edge.
module ps2_position_sequencer #(
  parameter int CLK_FILTER = 4,
  parameter int TIMEOUT    = 50000,
  parameter int X_STEP     = 32,
  parameter int X_MAX      = 96,
  parameter int Y_STEP     = 32,
  parameter int Y_MAX      = 320
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       vsync_i,
  output logic [9:0] x_red_counter_o,
  output logic [9:0] y_red_counter_o,
  output logic [2:0] color_reg_o,
  output logic [7:0] scan_code_o,
  output logic       scan_valid_o,
  output logic       frame_error_o,
  output logic       pending_o
);
  localparam int FW = $clog2(CLK_FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    ps2_clk_sync_q, ps2_data_sync_q;
  logic [2:0]    vsync_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          strobe, data_s, vsync_fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          scan_valid_d, frame_error_d;
  logic [7:0]    scan_code_q;
  logic          scan_valid_q, frame_error_q;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic [9:0]    px_q, px_d, py_q, py_d;
  logic [2:0]    pc_q, pc_d;
  logic          action;
  logic          pend_q;
  logic [9:0]    x_q, y_q;
  logic [2:0]    c_q;
  logic [10:0]   x_up, y_up;

  assign data_s     = ps2_data_sync_q[1];
  assign vsync_fall = vsync_sync_q[2] & ~vsync_sync_q[1];
  // Strobe on the cycle the filtered clock commits to a 1->0 change.
  assign strobe     = filt_q & ~ps2_clk_sync_q[1] & (filt_cnt_q == FW'(CLK_FILTER - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps2_clk_sync_q  <= 2'b11;
      ps2_data_sync_q <= 2'b11;
      vsync_sync_q    <= 3'b000;
      filt_q          <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      ps2_clk_sync_q  <= {ps2_clk_sync_q[0], ps2_clk_i};
      ps2_data_sync_q <= {ps2_data_sync_q[0], ps2_data_i};
      vsync_sync_q    <= {vsync_sync_q[1:0], vsync_i};
      if (ps2_clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(CLK_FILTER - 1)) begin
        filt_q     <= ps2_clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    to_cnt_d      = '0;
    scan_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      IDLE: if (strobe && !data_s) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (strobe) begin
        shift_d   = {data_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        parity_d = data_s;
        state_d  = STOP;
      end
      STOP: if (strobe) begin
        state_d = IDLE;
        if (data_s && (^shift_q ^ parity_q)) scan_valid_d = 1'b1;
        else frame_error_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !strobe) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        state_d       = IDLE;
        frame_error_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      to_cnt_q      <= to_cnt_d;
      scan_valid_q  <= scan_valid_d;
      frame_error_q <= frame_error_d;
      if (scan_valid_d) scan_code_q <= shift_q;
    end
  end

  // Saturating step arithmetic is one bit wider than the offsets.
  assign x_up = {1'b0, px_q} + 11'(X_STEP);
  assign y_up = {1'b0, py_q} + 11'(Y_STEP);

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    px_d   = px_q;
    py_d   = py_q;
    pc_d   = pc_q;
    action = 1'b0;
    if (scan_valid_q) begin
      if (scan_code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        ext_d  = 1'b0;
        action = 1'b1;
        if (ext_q && scan_code_q == 8'h6B)
          px_d = ({1'b0, px_q} >= 11'(X_STEP)) ? px_q - 10'(X_STEP) : '0;
        else if (ext_q && scan_code_q == 8'h74)
          px_d = (x_up > 11'(X_MAX)) ? 10'(X_MAX) : x_up[9:0];
        else if (ext_q && scan_code_q == 8'h75)
          py_d = ({1'b0, py_q} >= 11'(Y_STEP)) ? py_q - 10'(Y_STEP) : '0;
        else if (ext_q && scan_code_q == 8'h72)
          py_d = (y_up > 11'(Y_MAX)) ? 10'(Y_MAX) : y_up[9:0];
        else if (!ext_q && scan_code_q == 8'h29)
          pc_d = pc_q + 3'd1;
        else
          action = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      pc_q   <= 3'd1;
      pend_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= 3'd1;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      px_q  <= px_d;
      py_q  <= py_d;
      pc_q  <= pc_d;
      // A commit takes the pre-action pending values; a same-cycle action keeps pending set.
      if (action) pend_q <= 1'b1;
      else if (vsync_fall) pend_q <= 1'b0;
      if (vsync_fall) begin
        x_q <= px_q;
        y_q <= py_q;
        c_q <= pc_q;
      end
    end
  end

  assign x_red_counter_o = x_q;
  assign y_red_counter_o = y_q;
  assign color_reg_o     = c_q;
  assign scan_code_o     = scan_code_q;
  assign scan_valid_o    = scan_valid_q;
  assign frame_error_o   = frame_error_q;
  assign pending_o       = pend_q;
endmodule

// File: tb/tb_ps2_position_sequencer.sv
// Directed bench: PS/2 frames are bit-banged, a key-level model tracks pending/committed state.
module tb_ps2_position_sequencer;
  localparam int TO = 300;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ps2_clk = 1'b1, ps2_data = 1'b1, vsync = 1'b0;
  logic [9:0] x_o, y_o;
  logic [2:0] c_o;
  logic [7:0] code_o;
  logic sv_o, fe_o, pend_o;

  always #5 clk = ~clk;

  ps2_position_sequencer #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .vsync_i(vsync), .x_red_counter_o(x_o), .y_red_counter_o(y_o),
    .color_reg_o(c_o), .scan_code_o(code_o), .scan_valid_o(sv_o),
    .frame_error_o(fe_o), .pending_o(pend_o));

  int n_checks = 0, n_pass = 0;
  int sv_cnt = 0, fe_cnt = 0;
  bit chk_en = 1'b0;

  // Key-level model: pending and committed sprite state.
  int mx = 0, my = 0, mc = 1, px = 0, py = 0, pc = 1, mcode = 0;
  bit mpend = 0, ext = 0, brk = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (sv_o) sv_cnt++;
    if (fe_o) fe_cnt++;
    if (chk_en && rst_n) begin
      check("x", x_o, mx);
      check("y", y_o, my);
      check("color", c_o, mc);
      check("scan_code", code_o, mcode);
      check("pending", pend_o, mpend);
      check("scan_valid_idle", sv_o, 0);
      check("frame_error_idle", fe_o, 0);
    end
  end

  task automatic model_reset();
    mx = 0; my = 0; mc = 1; px = 0; py = 0; pc = 1; mcode = 0;
    mpend = 0; ext = 0; brk = 0;
  endtask

  task automatic model_key(input int c);
    mcode = c;
    if (c == 'hE0) ext = 1;
    else if (c == 'hF0) brk = 1;
    else if (brk) begin brk = 0; ext = 0; end
    else begin
      if (ext && c == 'h6B)       begin px = (px < 32) ? 0 : px - 32;        mpend = 1; end
      else if (ext && c == 'h74)  begin px = (px + 32 > 96) ? 96 : px + 32;  mpend = 1; end
      else if (ext && c == 'h75)  begin py = (py < 32) ? 0 : py - 32;        mpend = 1; end
      else if (ext && c == 'h72)  begin py = (py + 32 > 320) ? 320 : py + 32; mpend = 1; end
      else if (!ext && c == 'h29) begin pc = (pc + 1) % 8;                    mpend = 1; end
      ext = 0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(8);
    ps2_clk = 1'b0;
    cyc(8);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad);
    int sv0, fe0;
    logic par;
    chk_en = 1'b0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    par = ~^code ^ bad;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(1'b1);
    cyc(20);
    check("scan_valid_pulse", sv_cnt - sv0, bad ? 0 : 1);
    check("frame_error_pulse", fe_cnt - fe0, bad ? 1 : 0);
    if (!bad) model_key(int'(code));
    chk_en = 1'b1;
    cyc(2);
  endtask

  task automatic send_ext(input logic [7:0] code);
    send_frame(8'hE0, 0);
    send_frame(code, 0);
  endtask

  task automatic vsync_pulse();
    chk_en = 1'b0;
    vsync = 1'b1;
    cyc(5);
    vsync = 1'b0;
    cyc(6);
    mx = px; my = py; mc = pc; mpend = 0;
    chk_en = 1'b1;
    cyc(2);
  endtask

  initial begin
    int fe0, sv0;
    cyc(3);
    check("rst_x", x_o, 0);
    check("rst_y", y_o, 0);
    check("rst_color", c_o, 1);
    check("rst_code", code_o, 0);
    check("rst_pending", pend_o, 0);
    rst_n = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    cyc(5);

    // 1: extended right held pending until vsync
    send_ext(8'h74);
    check("t1_pending", pend_o, 1);
    check("t1_x_hold", x_o, 0);
    vsync_pulse();
    check("t1_x", x_o, 32);
    check("t1_pending_clr", pend_o, 0);

    // 2: saturation on both axes
    for (int i = 0; i < 5; i++) send_ext(8'h74);
    vsync_pulse();
    check("t2_x_max", x_o, 96);
    for (int i = 0; i < 4; i++) send_ext(8'h6B);
    vsync_pulse();
    check("t2_x_min", x_o, 0);
    for (int i = 0; i < 12; i++) send_ext(8'h72);
    vsync_pulse();
    check("t2_y_max", y_o, 320);

    // 3: bad parity
    send_frame(8'h29, 1);
    vsync_pulse();
    check("t3_color", c_o, 1);

    // 4: colour cycling, break and extended space ignored
    send_frame(8'hF0, 0);
    send_frame(8'h29, 0);
    check("t4_brk_nopend", pend_o, 0);
    send_frame(8'h29, 0);
    vsync_pulse();
    check("t4_color2", c_o, 2);
    for (int i = 0; i < 7; i++) send_frame(8'h29, 0);
    vsync_pulse();
    check("t4_wrap", c_o, 1);
    send_ext(8'h29);
    check("t4_ext_nopend", pend_o, 0);

    // 5: timeout abort, then left from 32
    send_ext(8'h74);
    vsync_pulse();
    check("t5_x32", x_o, 32);
    chk_en = 1'b0;
    fe0 = fe_cnt; sv0 = sv_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    cyc(TO + 60);
    check("t5_timeout_err", fe_cnt - fe0, 1);
    check("t5_timeout_nosv", sv_cnt - sv0, 0);
    // glitch with data low: a spurious strobe would start a frame and later time out
    fe0 = fe_cnt;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    cyc(1);
    ps2_clk = 1'b1;
    cyc(2);
    ps2_data = 1'b1;
    cyc(TO + 60);
    check("t5_glitch", fe_cnt - fe0, 0);
    chk_en = 1'b1;
    cyc(2);
    send_ext(8'h6B);
    vsync_pulse();
    check("t5_x0", x_o, 0);

    // 6: async reset mid-frame with a pending move
    send_ext(8'h74);
    send_frame(8'h29, 0);
    vsync_pulse();
    send_ext(8'h72);
    chk_en = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b0;
    cyc(4);
    ps2_clk = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_x", x_o, 0);
    check("t6_y", y_o, 0);
    check("t6_color", c_o, 1);
    check("t6_code", code_o, 0);
    check("t6_pending", pend_o, 0);
    check("t6_pulses", {sv_o, fe_o}, 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    model_reset();
    cyc(3);
    chk_en = 1'b1;
    cyc(2);
    send_frame(8'h29, 0);
    vsync_pulse();
    check("t6_color2", c_o, 2);
    check("t6_code29", code_o, 'h29);

    chk_en = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
